// File: rtl/mavg_pkg.sv
// mavg_pkg: shared limits, FSM state type and sum-width helper for moving_avg_decim.
package mavg_pkg;
    localparam int WIN_LOG2_MIN = 1;
    localparam int WIN_LOG2_MAX = 8;
    localparam int DEC_LOG2_MIN = 0;
    localparam int DEC_LOG2_MAX = 8;

    typedef enum logic {FILL, RUN} state_t;

    function automatic int sum_width(input int d_width, input int win_log2);
        return d_width + win_log2;
    endfunction
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-deep sample shift register that advances only on valid.
// Ports: clk, rst/clear (sync flush to zero), valid (shift enable), data_in (new sample),
// oldest (sample shifted in DEPTH valid cycles ago, zero until then).
module valid_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] oldest
);
    logic [DEPTH-1:0][WIDTH-1:0] line;

    always_ff @(posedge clk) begin
        if (rst || clear)
            line <= '0;
        else if (valid)
            line <= {line[DEPTH-2:0], data_in};
    end

    assign oldest = line[DEPTH-1];
endmodule

// File: rtl/moving_avg_decim.sv
// moving_avg_decim: running-sum moving average over 2^WIN_LOG2 samples with 2^DEC_LOG2 output decimation.
// Ports: clk, rst (sync active-high), clear (sync flush), data_in/data_in_valid (signed sample in),
// data_out/data_out_valid (registered mean and one-cycle strobe), primed (window full).
// Define MAVG_ROUND_EN to round half up instead of flooring the mean.
module moving_avg_decim
    import mavg_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int WIN_LOG2 = 3,
    parameter int DEC_LOG2 = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [D_WIDTH-1:0] data_in,
    input  logic               data_in_valid,
    output logic [D_WIDTH-1:0] data_out,
    output logic               data_out_valid,
    output logic               primed
);
    localparam int WIN = 1 << WIN_LOG2;
    localparam int SW  = sum_width(D_WIDTH, WIN_LOG2);
    localparam int CW  = WIN_LOG2 + 1;
    localparam int DW  = (DEC_LOG2 == 0) ? 1 : DEC_LOG2;

    if (WIN_LOG2 < WIN_LOG2_MIN || WIN_LOG2 > WIN_LOG2_MAX) begin : g_bad_win
        $error("WIN_LOG2 out of range");
    end
    if (DEC_LOG2 < DEC_LOG2_MIN || DEC_LOG2 > DEC_LOG2_MAX) begin : g_bad_dec
        $error("DEC_LOG2 out of range");
    end

    state_t               state, state_next;
    logic                 flush, accept, last_fill, produce, emit;
    logic [CW-1:0]        fill;
    logic [DW-1:0]        dec_cnt;
    logic [D_WIDTH-1:0]   oldest, mean;
    logic signed [SW-1:0] sum, sum_next;
    logic signed [SW:0]   biased;

    valid_delay_line #(.WIDTH(D_WIDTH), .DEPTH(WIN)) u_dly (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .valid(accept),
        .data_in(data_in),
        .oldest(oldest)
    );

    // A sample arriving together with rst/clear is dropped.
    assign flush     = rst | clear;
    assign accept    = data_in_valid & ~flush;
    assign last_fill = (state == FILL) && (fill == CW'(WIN - 1));
    assign produce   = accept && (state == RUN || last_fill);
    assign emit      = produce && (dec_cnt == '0);
    assign primed    = (fill == CW'(WIN));
    assign sum_next  = sum + SW'($signed(data_in)) - SW'($signed(oldest));

    // One guard bit keeps the rounding bias from wrapping at full scale.
`ifdef MAVG_ROUND_EN
    localparam logic signed [SW:0] HALF = (SW + 1)'(1) << (WIN_LOG2 - 1);
    assign biased = {sum_next[SW-1], sum_next} + HALF;
`else
    assign biased = {sum_next[SW-1], sum_next};
`endif
    assign mean = D_WIDTH'(biased >>> WIN_LOG2);

    always_comb begin
        state_next = (accept && last_fill) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (flush)
            state <= FILL;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            fill           <= '0;
            dec_cnt        <= '0;
            sum            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= emit;
            if (accept) begin
                sum <= sum_next;
                if (state == FILL)
                    fill <= fill + 1'b1;
            end
            if (produce)
                dec_cnt <= (DEC_LOG2 == 0) ? '0 : dec_cnt + 1'b1;
            if (emit)
                data_out <= mean;
        end
    end
endmodule

// File: tb/tb_moving_avg_decim.sv
// tb_moving_avg_decim: scoreboard bench for moving_avg_decim (DEC 1 and DEC 4 instances).
module tb_moving_avg_decim;
    localparam int W = 32;

    typedef struct {
        logic signed [W-1:0] val;
        int                  cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst, clear, din_v;
    logic signed [W-1:0] din;
    logic signed [W-1:0] dout0, dout4;
    logic                v0, v4, p0, p4;

    exp_t    q0[$], q4[$];
    exp_t    e0, e4;
    longint  hist[$];
    int      d4 = 0;
    int      checks = 0, failures = 0, cyc = 0, n0 = 0, n4 = 0;
    int      base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    moving_avg_decim #(.D_WIDTH(W), .WIN_LOG2(3), .DEC_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .data_in(din), .data_in_valid(din_v),
        .data_out(dout0), .data_out_valid(v0), .primed(p0)
    );

    moving_avg_decim #(.D_WIDTH(W), .WIN_LOG2(3), .DEC_LOG2(2)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .data_in(din), .data_in_valid(din_v),
        .data_out(dout4), .data_out_valid(v4), .primed(p4)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [W-1:0] ref_mean();
        longint s = 0;
        for (int i = 0; i < 8; i++) s += hist[hist.size() - 1 - i];
`ifdef MAVG_ROUND_EN
        s += 4;
`endif
        return W'(s >>> 3);
    endfunction

    task automatic flush_model();
        hist.delete();
        d4 = 0;
    endtask

    task automatic send(input logic signed [W-1:0] s);
        din   = s;
        din_v = 1'b1;
        hist.push_back(longint'(s));
        if (hist.size() >= 8) begin
            q0.push_back('{ref_mean(), cyc + 1});
            if (d4 == 0) q4.push_back('{ref_mean(), cyc + 1});
            d4 = (d4 + 1) % 4;
        end
        @(posedge clk);
        #1;
        din_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        idle(3);
        check({tag, "_q0_left"}, q0.size(), 0);
        check({tag, "_q4_left"}, q4.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (v0 === 1'b1) begin
            n0++;
            if (q0.size() == 0) check("dut0_unexpected_strobe", 1, 0);
            else begin
                e0 = q0.pop_front();
                check("dut0_data", dout0, e0.val);
                check("dut0_latency", cyc, e0.cyc);
            end
        end
        if (v4 === 1'b1) begin
            n4++;
            if (q4.size() == 0) check("dut4_unexpected_strobe", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("dut4_data", dout4, e4.val);
                check("dut4_latency", cyc, e4.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; din_v = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout0", dout0, 0);
        check("rst_valid0", v0, 0);
        check("rst_primed0", p0, 0);
        check("rst_dout4", dout4, 0);
        check("rst_primed4", p4, 0);

        base = n0;
        for (int i = 0; i < 7; i++) send(100);
        check("primed_before_win", p0, 0);
        check("no_strobe_in_fill", n0 - base, 0);
        send(100);
        check("first_valid", v0, 1);
        check("first_out", dout0, 100);
        check("primed_after_win", p0, 1);
        idle(1);
        check("strobe_one_cycle", v0, 0);
        check("hold_out", dout0, 100);
        drain("win8");
        check("win8_strobes", n0 - base, 1);

        do_reset();
        for (int i = 0; i < 7; i++) send(0);
        send(4);
`ifdef MAVG_ROUND_EN
        check("pos_half", dout0, 1);
`else
        check("pos_half", dout0, 0);
`endif
        drain("pos");

        do_reset();
        for (int i = 0; i < 7; i++) send(0);
        send(-4);
`ifdef MAVG_ROUND_EN
        check("neg_half", dout0, 0);
`else
        check("neg_half", dout0, -1);
`endif
        drain("neg");

        do_reset();
        base = n4;
        for (int i = 0; i < 20; i++) send(5);
        drain("dec4");
        check("dec4_strobes", n4 - base, 4);
        check("dec4_last", dout4, 5);

        do_reset();
        base = n0;
        for (int i = 1; i <= 16; i++) begin
            send(i);
            idle($urandom_range(0, 3));
        end
        drain("ramp");
        check("ramp_strobes", n0 - base, 9);
`ifdef MAVG_ROUND_EN
        check("ramp_last", dout0, 13);
`else
        check("ramp_last", dout0, 12);
`endif

        for (int i = 0; i < 10; i++) send(50);
        do_reset();
        check("mid_rst_primed", p0, 0);
        for (int i = 0; i < 8; i++) send(-8);
        drain("midrst");
        check("mid_rst_out", dout0, -8);

        do_reset();
        for (int i = 0; i < 5; i++) send(3);
        din = 9; din_v = 1'b1; clear = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        din_v = 1'b0; clear = 1'b0;
        check("clear_primed", p0, 0);
        check("clear_no_strobe", v0, 0);
        base = n0;
        for (int i = 0; i < 7; i++) send(7);
        check("clear_refill_primed", p0, 0);
        send(7);
        drain("clear");
        check("clear_strobes", n0 - base, 1);
        check("clear_out", dout0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/moving_avg_decim.md
MOVING_AVG_DECIM -- requirements
Module: moving_avg_decim

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, meaning input/output sample width (signed two's complement).
REQ-002 SHALL have parameter WIN_LOG2, default 3, meaning log2 of averaging window length WIN (1..8).
REQ-003 SHALL have parameter DEC_LOG2, default 0, meaning log2 of output decimation factor DEC (0..8).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of window state, same effect as rst.
REQ-007 SHALL have port data_in  input  D_WIDTH  signed sample.
REQ-008 SHALL have port data_in_valid  input  1  qualifies data_in; no backpressure.
REQ-009 SHALL have port data_out  output  D_WIDTH  signed window mean.
REQ-010 SHALL have port data_out_valid  output  1  single-cycle strobe qualifying data_out.
REQ-011 SHALL have port primed  output  1  high once WIN samples have been accepted since last reset/clear.

Function
REQ-012 SHALL accept a sample on every cycle with data_in_valid=1; cycles with data_in_valid=0 change no state.
REQ-013 SHALL hold a running sum of width D_WIDTH+WIN_LOG2; per accepted sample: sum <= sum + data_in - oldest, where oldest is the sample accepted WIN accepted-samples earlier (0 before priming).
REQ-014 SHALL keep a fill counter 0..WIN, incremented per accepted sample, saturating at WIN; primed = (fill==WIN).
REQ-015 SHALL compute mean = updated sum arithmetically shifted right by WIN_LOG2, truncated to D_WIDTH (no overflow possible).
REQ-016 SHALL use states FILL (fill<WIN) and RUN (fill==WIN); FILL->RUN on the WIN-th accepted sample; RUN->FILL only on rst/clear.
REQ-017 SHALL emit no data_out_valid in FILL; the WIN-th accepted sample SHALL produce the first output.
REQ-018 SHALL, in RUN, emit an output on the first RUN sample and every DEC-th accepted sample thereafter (decimation counter modulo DEC, wraps to 0).
REQ-019 SHALL register data_out and data_out_valid: latency exactly 1 clock from accepting the producing sample.
REQ-020 SHALL hold data_out at last value between strobes; data_out_valid high for exactly one cycle per output.
REQ-021 SHALL give clear priority over a simultaneous data_in_valid: that sample is dropped; data_out_valid=0 next cycle.

Reset
REQ-022 SHALL on rst (or clear) set sum=0, fill=0, decimation counter=0, delay-line contents=0, data_out=0, data_out_valid=0, primed=0.
REQ-023 SHALL treat rst asserted mid-window identically: partial window discarded, FILL restarts from zero.

Configuration
REQ-024 SHALL, with MAVG_ROUND_EN defined, add 2^(WIN_LOG2-1) to the sum before the shift (round half up).
REQ-025 SHALL, without MAVG_ROUND_EN, truncate toward negative infinity (plain arithmetic shift).

Structure
REQ-026 SHALL place WIN_LOG2/DEC_LOG2 range limits and the sum-width function in shared package mavg_pkg.
REQ-027 SHALL implement the oldest-sample store as sub-module valid_delay_line (WIN-deep register shift advancing only on data_in_valid, synchronous clear).

Verification
REQ-028 SHALL verify: WIN_LOG2=3, DEC_LOG2=0, 8 samples of 100 -> first data_out_valid 1 cycle after 8th sample, data_out=100, primed=1.
REQ-029 SHALL verify: window of seven 0 and one 4 -> data_out=0 without MAVG_ROUND_EN, 1 with it; one -4 instead -> -1 without, 0 with.
REQ-030 SHALL verify: DEC_LOG2=2, 20 samples of 5 -> exactly 4 strobes, after samples 8, 12, 16, 20, each data_out=5.
REQ-031 SHALL verify: random idle cycles (data_in_valid=0) between 16 samples ramp 1..16 -> outputs equal no-gap run (floor: 4,5,...,12).
REQ-032 SHALL verify: clear asserted with data_in_valid=1 after 5 samples -> primed=0, no strobe, 8 further samples of 7 -> single first output 7.
